// File: rtl/axil_rr_master_arb.sv
// Two-requester round-robin arbiter that shares one AXI4-Lite master port.
// One single-word read or write is in flight at a time. Results return on a one-cycle req_done pulse.
module axil_rr_master_arb #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,

  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     req_rdata,
  output logic [1:0]            req_resp,
  output logic [1:0]            grant,

  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [1:0]          req_done_q, req_done_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic [1:0]          req_resp_q, req_resp_d;

  logic                win;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // With both requesters pending, the one that did not win last time goes next.
  always_comb begin
    win       = (req_valid == 2'b11) ? ~last_grant_q : ~req_valid[0];
    sel_addr  = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    req_done_d   = req_done_q;
    req_rdata_d  = req_rdata_q;
    req_resp_d   = req_resp_q;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d      = win ? 2'b10 : 2'b01;
          last_grant_d = win;
          addr_d       = {sel_addr[ADDR_W-1:2], 2'b00};
          if (req_write[win]) begin
            wdata_d   = sel_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      // Address and data channels complete independently, in either order or together.
      WR: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          req_resp_d  = m_axi_bresp;
          req_rdata_d = '0;
          req_done_d  = grant_q;
          state_d     = DONE;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          req_resp_d  = m_axi_rresp;
          req_rdata_d = m_axi_rdata;
          req_done_d  = grant_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        req_done_d  = 2'b00;
        req_rdata_d = '0;
        req_resp_d  = 2'b00;
        grant_d     = 2'b00;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      req_done_q   <= 2'b00;
      req_rdata_q  <= '0;
      req_resp_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      req_done_q   <= req_done_d;
      req_rdata_q  <= req_rdata_d;
      req_resp_q   <= req_resp_d;
    end
  end

  assign req_done      = req_done_q;
  assign req_rdata     = req_rdata_q;
  assign req_resp      = req_resp_q;
  assign grant         = grant_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = {(DATA_W/8){1'b1}};
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_rr_master_arb.sv
// Directed bench for axil_rr_master_arb with a small four-register AXI4-Lite slave model.
// The slave's ready delays, response codes and B-channel hold are set from the stimulus sequence.
module tb_axil_rr_master_arb;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_done;
  logic [31:0] req_rdata;
  logic [1:0]  req_resp;
  logic [1:0]  grant;

  logic [3:0]  m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [3:0]  m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int n_checks = 0;
  int n_fails  = 0;

  axil_rr_master_arb #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp), .grant(grant),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  // Slave model: ready delays count cycles of VALID before READY, B/R follow one cycle later.
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        b_hold = 1'b0;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [3:0]  aw_addr_s;
  logic [31:0] w_data_s;
  logic [31:0] mem [4];

  wire         aw_hs   = m_axi_awvalid && m_axi_awready;
  wire         w_hs    = m_axi_wvalid && m_axi_wready;
  wire         aw_have = aw_got || aw_hs;
  wire         w_have  = w_got || w_hs;
  wire [3:0]   wr_addr = aw_hs ? m_axi_awaddr : aw_addr_s;
  wire [31:0]  wr_data = w_hs ? m_axi_wdata : w_data_s;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt == aw_delay);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt == w_delay);
  assign m_axi_arready = m_axi_arvalid;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1; aw_addr_s <= m_axi_awaddr; aw_cnt <= 0;
      end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_got <= 1'b1; w_data_s <= m_axi_wdata; w_cnt <= 0;
      end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
      if (aw_have && w_have && !m_axi_bvalid && !b_hold) begin
        m_axi_bvalid <= 1'b1; m_axi_bresp <= bresp_cfg;
        mem[wr_addr[3:2]] <= wr_data;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1; m_axi_rdata <= mem[m_axi_araddr[3:2]]; m_axi_rresp <= rresp_cfg;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // Protocol monitor: early VALID drops, VALID held past handshake, BREADY too early, mixed channels.
  int   proto_viol = 0;
  int   overlap    = 0;
  int   done_cnt0  = 0;
  int   done_cnt1  = 0;
  logic prev_rst = 1'b1, prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;

  always @(posedge ACLK) begin
    if (!prev_rst) begin
      if (prev_awv && !prev_awr && !m_axi_awvalid) proto_viol <= proto_viol + 1;
      if (prev_awv && prev_awr && m_axi_awvalid)   proto_viol <= proto_viol + 1;
      if (prev_wv && !prev_wr && !m_axi_wvalid)    proto_viol <= proto_viol + 1;
      if (prev_wv && prev_wr && m_axi_wvalid)      proto_viol <= proto_viol + 1;
    end
    if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) proto_viol <= proto_viol + 1;
    if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready))
      overlap <= overlap + 1;
    if (req_done[0] === 1'b1) done_cnt0 <= done_cnt0 + 1;
    if (req_done[1] === 1'b1) done_cnt1 <= done_cnt1 + 1;
    prev_rst <= ARESET;
    prev_awv <= m_axi_awvalid; prev_awr <= m_axi_awready;
    prev_wv  <= m_axi_wvalid;  prev_wr  <= m_axi_wready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic wr, input logic [3:0] addr, input logic [31:0] data);
    req_valid[idx]         = 1'b1;
    req_write[idx]         = wr;
    req_addr[idx*4 +: 4]   = addr;
    req_wdata[idx*32 +: 32] = data;
  endtask

  // Bounded wait for req_done[idx]; a timeout shows up as a wrong cycle count.
  task automatic waitDone(input int idx, output int cyc);
    cyc = 0;
    do begin
      @(negedge ACLK);
      cyc++;
    end while (req_done[idx] !== 1'b1 && cyc < 40);
  endtask

  task automatic waitAnyDone(output int cyc);
    cyc = 0;
    do begin
      @(negedge ACLK);
      cyc++;
    end while (req_done === 2'b00 && cyc < 40);
  endtask

  task automatic finishCmd(input int idx);
    req_valid[idx] = 1'b0;
    @(negedge ACLK);
  endtask

  int cyc, saved, n0, n1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge ACLK);
    checkOutput("rst_grant", {30'd0, grant}, 32'h0);
    checkOutput("rst_done_resp", {28'd0, req_done, req_resp}, 32'h0);
    checkOutput("rst_rdata", req_rdata, 32'h0);
    checkOutput("rst_valid_ready",
                {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
    checkOutput("rst_addr", {24'd0, m_axi_awaddr, m_axi_araddr}, 32'h0);
    checkOutput("rst_wdata", m_axi_wdata, 32'h0);
    checkOutput("wstrb", {28'd0, m_axi_wstrb}, 32'hF);
    checkOutput("prot", {26'd0, m_axi_awprot, m_axi_arprot}, 32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);

    $display("[TB] single write from requester 0");
    applyStimulus(0, 1'b1, 4'h4, 32'h0000_00A5);
    @(negedge ACLK);
    checkOutput("wr_grant", {30'd0, grant}, 32'h1);
    checkOutput("wr_awaddr", {28'd0, m_axi_awaddr}, 32'h4);
    checkOutput("wr_wdata", m_axi_wdata, 32'hA5);
    checkOutput("wr_valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
    waitDone(0, cyc);
    checkOutput("wr_latency", cyc, 2);
    checkOutput("wr_resp", {30'd0, req_resp}, 32'h0);
    checkOutput("wr_rdata_zero", req_rdata, 32'h0);
    checkOutput("wr_done_onehot", {30'd0, req_done}, 32'h1);
    checkOutput("wr_mem", mem[1], 32'hA5);
    finishCmd(0);
    checkOutput("wr_grant_clear", {30'd0, grant, req_done}, 32'h0);

    $display("[TB] requester 1 fills registers, requester 0 reads back");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1'b1, 4'(k * 4), 32'(k + 1));
      waitDone(1, cyc);
      checkOutput("fill_latency", cyc, 3);
      finishCmd(1);
    end
    saved = done_cnt1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b0, 4'(k * 4), 32'h0);
      waitDone(0, cyc);
      checkOutput("rd_latency", cyc, 3);
      checkOutput("rd_data", req_rdata, 32'(k + 1));
      checkOutput("rd_resp", {30'd0, req_resp}, 32'h0);
      finishCmd(0);
    end
    @(negedge ACLK);
    checkOutput("rd_no_done1", done_cnt1, saved);

    $display("[TB] unaligned read address is word aligned");
    applyStimulus(0, 1'b0, 4'h7, 32'h0);
    @(negedge ACLK);
    checkOutput("rd_araddr", {28'd0, m_axi_araddr}, 32'h4);
    checkOutput("rd_arvalid", {31'd0, m_axi_arvalid}, 32'h1);
    waitDone(0, cyc);
    checkOutput("rd_unaligned_data", req_rdata, 32'h2);
    finishCmd(0);

    applyStimulus(1, 1'b0, 4'hC, 32'h0);
    waitDone(1, cyc);
    checkOutput("rd_req1_data", req_rdata, 32'h4);
    finishCmd(1);

    $display("[TB] both requesters held valid");
    applyStimulus(0, 1'b1, 4'h0, 32'h100);
    applyStimulus(1, 1'b1, 4'h4, 32'h200);
    n0 = 1; n1 = 1;
    for (int i = 0; i < 6; i++) begin
      waitAnyDone(cyc);
      checkOutput("fair_order", {30'd0, req_done}, (i % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput("fair_spacing", cyc, (i == 0) ? 3 : 4);
      if (req_done[0] === 1'b1) begin
        if (n0 < 3) begin applyStimulus(0, 1'b1, 4'h0, 32'h100 + 32'(n0)); n0++; end
        else req_valid[0] = 1'b0;
      end else begin
        if (n1 < 3) begin applyStimulus(1, 1'b1, 4'h4, 32'h200 + 32'(n1)); n1++; end
        else req_valid[1] = 1'b0;
      end
    end
    @(negedge ACLK);
    checkOutput("fair_mem0", mem[0], 32'h102);
    checkOutput("fair_mem1", mem[1], 32'h202);

    $display("[TB] write channel backpressure");
    aw_delay = 0; w_delay = 3;
    applyStimulus(0, 1'b1, 4'h8, 32'hB0);
    @(negedge ACLK);
    checkOutput("bp_a_c1", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h6);
    @(negedge ACLK);
    checkOutput("bp_a_c2", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h2);
    waitDone(0, cyc);
    checkOutput("bp_a_latency", cyc, 4);
    checkOutput("bp_a_mem", mem[2], 32'hB0);
    finishCmd(0);

    aw_delay = 3; w_delay = 0;
    applyStimulus(0, 1'b1, 4'hC, 32'hB1);
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("bp_b_c2", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h4);
    waitDone(0, cyc);
    checkOutput("bp_b_latency", cyc, 4);
    checkOutput("bp_b_mem", mem[3], 32'hB1);
    finishCmd(0);

    aw_delay = 2; w_delay = 2;
    applyStimulus(0, 1'b1, 4'h0, 32'hB2);
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("bp_c_c2", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h6);
    waitDone(0, cyc);
    checkOutput("bp_c_latency", cyc, 3);
    checkOutput("bp_c_mem", mem[0], 32'hB2);
    finishCmd(0);
    aw_delay = 0; w_delay = 0;

    $display("[TB] error responses pass through");
    bresp_cfg = 2'b10;
    saved = done_cnt0;
    applyStimulus(0, 1'b1, 4'h8, 32'hE0);
    waitDone(0, cyc);
    checkOutput("err_bresp", {30'd0, req_resp}, 32'h2);
    finishCmd(0);
    @(negedge ACLK);
    checkOutput("err_done_once", done_cnt0, saved + 1);
    bresp_cfg = 2'b00; rresp_cfg = 2'b10;
    applyStimulus(0, 1'b0, 4'h8, 32'h0);
    waitDone(0, cyc);
    checkOutput("err_rresp", {30'd0, req_resp}, 32'h2);
    checkOutput("err_rdata", req_rdata, 32'hE0);
    finishCmd(0);
    rresp_cfg = 2'b00;
    applyStimulus(0, 1'b0, 4'h8, 32'h0);
    waitDone(0, cyc);
    checkOutput("err_recover_resp", {30'd0, req_resp}, 32'h0);
    checkOutput("err_recover_latency", cyc, 3);
    finishCmd(0);

    $display("[TB] reset while waiting for write response");
    b_hold = 1'b1;
    applyStimulus(0, 1'b1, 4'hC, 32'hDD);
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("rstmid_bready", {31'd0, m_axi_bready}, 32'h1);
    saved = done_cnt0;
    ARESET = 1'b1; req_valid = 2'b00;
    @(negedge ACLK);
    checkOutput("rstmid_grant_done", {28'd0, grant, req_done}, 32'h0);
    checkOutput("rstmid_valid_ready",
                {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
    checkOutput("rstmid_addr_data", {24'd0, m_axi_awaddr, m_axi_araddr} | m_axi_wdata, 32'h0);
    checkOutput("rstmid_resp_rdata", {30'd0, req_resp} | req_rdata, 32'h0);
    ARESET = 1'b0; b_hold = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("rstmid_no_done", done_cnt0, saved);
    applyStimulus(0, 1'b1, 4'hC, 32'h77);
    @(negedge ACLK);
    checkOutput("rstmid_regrant", {30'd0, grant}, 32'h1);
    waitDone(0, cyc);
    checkOutput("rstmid_latency", cyc, 2);
    checkOutput("rstmid_resp", {30'd0, req_resp}, 32'h0);
    finishCmd(0);
    checkOutput("rstmid_mem", mem[3], 32'h77);

    checkOutput("proto_viol", proto_viol, 0);
    checkOutput("chan_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
